// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters with read-data return; BRAM_ARB_LOCK_EN adds a requester-1 burst lock
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic [DATA_WIDTH/8-1:0] we0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  output logic                    gnt0,
  output logic                    rvalid0,
  output logic [DATA_WIDTH-1:0]   rdata0,
  input  logic                    req1,
  input  logic [DATA_WIDTH/8-1:0] we1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    gnt1,
  output logic                    rvalid1,
  output logic [DATA_WIDTH-1:0]   rdata1,
`ifdef BRAM_ARB_LOCK_EN
  input  logic                    lock1,
`endif
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);
  logic last, pend_v, pend_id, hold;
`ifdef BRAM_ARB_LOCK_EN
  logic locked;
  assign hold = locked & req1 & lock1;
`else
  assign hold = 1'b0;
`endif
  // grant: lock wins, else lone requester, else the one not granted last; RAM port follows the winner
  always_comb begin
    gnt1      = !reset && req1 && (hold || !req0 || !last);
    gnt0      = !reset && req0 && !gnt1;
    ram_we    = gnt1 ? we1 : gnt0 ? we0 : '0;
    ram_addr  = gnt1 ? addr1 : addr0;
    ram_wdata = gnt1 ? wdata1 : wdata0;
  end
  // priority pointer and one-deep read tracker matching the RAM's 1-cycle latency
  always_ff @(posedge clk) begin
    if (reset) begin
      last    <= 1'b1;
      pend_v  <= 1'b0;
      pend_id <= 1'b0;
`ifdef BRAM_ARB_LOCK_EN
      locked  <= 1'b0;
`endif
    end else begin
      if (gnt0 || gnt1) last <= gnt1;
      pend_v  <= (gnt0 && we0 == '0) || (gnt1 && we1 == '0);
      pend_id <= gnt1;
`ifdef BRAM_ARB_LOCK_EN
      locked  <= gnt1 & lock1;
`endif
    end
  end
  assign rvalid0 = pend_v & ~pend_id;
  assign rvalid1 = pend_v & pend_id;
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: vector-table and sequence checks of bram_port_arbiter against a read-first BRAM model (lock checks under BRAM_ARB_LOCK_EN)
module tb_bram_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [3:0] we0 = '0, we1 = '0, ram_we;
  logic [8:0] addr0 = '0, addr1 = '0, ram_addr;
  logic [31:0] wdata0 = '0, wdata1 = '0, ram_wdata, ram_rdata, rdata0, rdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef BRAM_ARB_LOCK_EN
    .lock1(lock1),
`endif
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  // BRAM model: registered read, write committed one edge later so the next-cycle read still sees the old word
  logic [31:0] mem [0:511];
  logic [3:0] pw = '0;
  logic [8:0] pa = '0;
  logic [31:0] pd = '0;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    for (int b = 0; b < 4; b++) if (pw[b]) mem[pa][8*b +: 8] <= pd[8*b +: 8];
    pw <= ram_we;
    pa <= ram_addr;
    pd <= ram_wdata;
  end
  typedef struct packed {
    logic rst; logic r0; logic [3:0] w0; logic [8:0] a0; logic [31:0] d0;
    logic r1; logic [3:0] w1; logic [8:0] a1; logic [31:0] d1;
    logic g0; logic g1; logic [3:0] rwe; logic rv0; logic rv1; logic [31:0] rd;
  } vec_t;
  localparam logic H = 1'b1, L = 1'b0;
  localparam logic [3:0] RD = 4'h0;
  localparam logic [8:0] A0 = 9'h000;
  localparam logic [31:0] Z = 32'h0;
  vec_t tv [22];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rst, r0, input logic [3:0] w0, input logic [8:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [8:0] a1, input logic [31:0] d1, input logic lk);
    @(negedge clk);
    reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = lk;
    #1;
    n_cmp++;
    if (gnt0 && gnt1) begin
      n_bad++;
      $display("FAIL dual_gnt: got gnt0=1 gnt1=1 want at most one");
    end
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h010] = 32'hDEADBEEF;
    mem[9'h020] = 32'h11223344;
    mem[9'h030] = 32'hCAFEF00D;
    mem[9'h040] = 32'h0BADC0DE;
    mem[9'h1FF] = 32'hAAAA5555;
    tv[0]  = '{H, H, RD, 9'h010, Z, L, RD, A0, Z, L, L, RD, L, L, Z};
    tv[1]  = '{L, H, RD, 9'h010, Z, L, RD, A0, Z, H, L, RD, L, L, Z};
    tv[2]  = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, H, L, 32'hDEADBEEF};
    tv[3]  = '{H, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, L, L, Z};
    tv[4]  = '{L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, H, L, RD, L, L, Z};
    tv[5]  = '{L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, L, H, RD, H, L, 32'hDEADBEEF};
    tv[6]  = '{L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, H, L, RD, L, H, 32'h11223344};
    tv[7]  = '{L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, L, H, RD, H, L, 32'hDEADBEEF};
    tv[8]  = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, L, H, 32'h11223344};
    tv[9]  = '{L, L, RD, A0, Z, H, 4'hF, 9'h1FF, 32'h12345678, L, H, 4'hF, L, L, Z};
    tv[10] = '{L, H, RD, 9'h1FF, Z, L, RD, A0, Z, H, L, RD, L, L, Z};
    tv[11] = '{L, L, RD, A0, Z, H, RD, 9'h1FF, Z, L, H, RD, H, L, 32'hAAAA5555};
    tv[12] = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, L, H, 32'h12345678};
    tv[13] = '{L, H, 4'h2, 9'h020, 32'h0000AB00, L, RD, A0, Z, H, L, 4'h2, L, L, Z};
    tv[14] = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, L, L, Z};
    tv[15] = '{L, H, RD, 9'h020, Z, L, RD, A0, Z, H, L, RD, L, L, Z};
    tv[16] = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, H, L, 32'h1122AB44};
    tv[17] = '{H, H, RD, 9'h030, Z, L, RD, A0, Z, L, L, RD, L, L, Z};
    tv[18] = '{L, H, RD, 9'h030, Z, H, RD, 9'h040, Z, H, L, RD, L, L, Z};
    tv[19] = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, H, L, 32'hCAFEF00D};
    tv[20] = '{L, L, RD, A0, Z, H, RD, 9'h040, Z, L, H, RD, L, L, Z};
    tv[21] = '{L, L, RD, A0, Z, L, RD, A0, Z, L, L, RD, L, H, 32'h0BADC0DE};
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].rst, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0, tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1, L);
      chk($sformatf("row%0d gnt0", i), 32'(gnt0), 32'(tv[i].g0));
      chk($sformatf("row%0d gnt1", i), 32'(gnt1), 32'(tv[i].g1));
      chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tv[i].rwe));
      chk($sformatf("row%0d rvalid0", i), 32'(rvalid0), 32'(tv[i].rv0));
      chk($sformatf("row%0d rvalid1", i), 32'(rvalid1), 32'(tv[i].rv1));
      if (tv[i].rv0) chk($sformatf("row%0d rdata0", i), rdata0, tv[i].rd);
      if (tv[i].rv1) chk($sformatf("row%0d rdata1", i), rdata1, tv[i].rd);
    end
    // continuous contention: requester 0 reads, requester 1 writes, grants alternate with no bubble
    drive(H, L, RD, A0, Z, L, RD, A0, Z, L);
    for (int k = 0; k < 8; k++) begin
      drive(L, H, RD, 9'h010, Z, H, 4'hF, 9'h100, 32'h5A5A5A5A, L);
      chk($sformatf("alt%0d gnt0", k), 32'(gnt0), 32'(k % 2 == 0));
      chk($sformatf("alt%0d gnt1", k), 32'(gnt1), 32'(k % 2 == 1));
      chk($sformatf("alt%0d ram_we", k), 32'(ram_we), (k % 2 == 1) ? 32'hF : 32'h0);
      chk($sformatf("alt%0d rvalid0", k), 32'(rvalid0), 32'(k % 2 == 1));
      chk($sformatf("alt%0d rvalid1", k), 32'(rvalid1), 32'h0);
      if (k % 2 == 1) chk($sformatf("alt%0d rdata0", k), rdata0, 32'hDEADBEEF);
    end
    drive(L, L, RD, A0, Z, L, RD, A0, Z, L);
    drive(L, H, RD, 9'h100, Z, L, RD, A0, Z, L);
    drive(L, L, RD, A0, Z, L, RD, A0, Z, L);
    chk("alt_readback rvalid0", 32'(rvalid0), 32'h1);
    chk("alt_readback rdata0", rdata0, 32'h5A5A5A5A);
`ifdef BRAM_ARB_LOCK_EN
    // locked burst: requester 1 keeps the port for three grants despite requester 0 waiting
    drive(H, L, RD, A0, Z, L, RD, A0, Z, L);
    drive(L, H, RD, 9'h010, Z, L, RD, A0, Z, L);
    chk("lock_pre gnt0", 32'(gnt0), 32'h1);
    for (int k = 0; k < 3; k++) begin
      drive(L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, H);
      chk($sformatf("lock%0d gnt1", k), 32'(gnt1), 32'h1);
      chk($sformatf("lock%0d gnt0", k), 32'(gnt0), 32'h0);
    end
    drive(L, H, RD, 9'h010, Z, H, RD, 9'h020, Z, L);
    chk("unlock gnt0", 32'(gnt0), 32'h1);
    chk("unlock gnt1", 32'(gnt1), 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
